// File: rtl/serial_word_deser.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_deser
// Purpose  : Serial-to-parallel collector with a one-word output holding slot.
// Revision : 1.0
// ============================================================================
module serial_word_deser #(
  parameter int WIDTH   = 100,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               bit_valid,
  input  logic               bit_in,
  output logic               bit_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_word,
  output logic [COUNT_W-1:0] word_count
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_word_q, out_word_d;
  logic               out_valid_q, out_valid_d;
  logic [COUNT_W-1:0] word_count_q, word_count_d;

  logic slot_free;
  logic accept;

  always_comb begin
    slot_free    = !out_valid_q || out_ready;
    bit_ready    = !flush && (cnt_q < CNT_FULL);
    accept       = bit_valid && bit_ready;

    sr_d         = sr_q;
    cnt_d        = cnt_q;
    out_word_d   = out_word_q;
    out_valid_d  = out_valid_q;
    word_count_d = word_count_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // A word stalled behind a busy slot moves out as soon as the slot frees.
    if ((cnt_q == CNT_FULL) && slot_free) begin
      out_word_d   = sr_q;
      out_valid_d  = 1'b1;
      cnt_d        = '0;
      word_count_d = word_count_q + COUNT_W'(1);
    end

    if (accept) begin
      sr_d = {sr_q[WIDTH-2:0], bit_in};
      if (cnt_q == CNT_LAST) begin
        if (slot_free) begin
          out_word_d   = {sr_q[WIDTH-2:0], bit_in};
          out_valid_d  = 1'b1;
          cnt_d        = '0;
          word_count_d = word_count_q + COUNT_W'(1);
        end else begin
          cnt_d = CNT_FULL;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Flush comes last so a same-cycle handoff of a full word still happens.
    if (flush) begin
      cnt_d = '0;
      sr_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q         <= '0;
      cnt_q        <= '0;
      out_word_q   <= '0;
      out_valid_q  <= 1'b0;
      word_count_q <= '0;
    end else begin
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      out_word_q   <= out_word_d;
      out_valid_q  <= out_valid_d;
      word_count_q <= word_count_d;
    end
  end

  assign out_word   = out_word_q;
  assign out_valid  = out_valid_q;
  assign word_count = word_count_q;

endmodule
`default_nettype wire
